// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_pkg
//  Description : Shared types and helpers for the convolution engine MAC
//                array: element bit-offset helper, accumulator width
//                derivation and a fixed-width complex sample type.
//  Revision    : 1.0  initial parametrised release
// ============================================================================
package conv_pkg;

    localparam int c_cplx_data_w = 16;

    // One complex sample as laid out on the tile buses: imag in the upper half
    typedef struct packed {
        logic signed [c_cplx_data_w-1:0] im;
        logic signed [c_cplx_data_w-1:0] re;
    } cplx_fixed;

    // Accumulator width: full-precision product plus headroom for MAX_CH adds
    function automatic int acc_w_f(input int data_w, input int max_ch);
        return 2 * data_w + 1 + $clog2(max_ch);
    endfunction

    // Bit offset of element (tile,row,col) in a tile-major, row-major bus
    function automatic int elem_off(input int tile, input int row, input int col,
                                    input int tile_dim, input int elem_w);
        return ((tile * tile_dim + row) * tile_dim + col) * elem_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/complex_mult_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : complex_mult_pipe
//  Description : Full-precision complex multiply (a*b) followed by MUL_LAT
//                register stages; every stage holds while en is low.
//  Revision    : 1.0  initial parametrised release
// ============================================================================
module complex_mult_pipe #(
    parameter int DATA_W  = 16,
    parameter int MUL_LAT = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] a_re,
    input  logic signed [DATA_W-1:0] a_im,
    input  logic signed [DATA_W-1:0] b_re,
    input  logic signed [DATA_W-1:0] b_im,
    output logic signed [2*DATA_W:0] p_re,
    output logic signed [2*DATA_W:0] p_im
);

    localparam int c_pw = 2 * DATA_W + 1;

    logic signed [2*DATA_W-1:0] w_rr;
    logic signed [2*DATA_W-1:0] w_ii;
    logic signed [2*DATA_W-1:0] w_ri;
    logic signed [2*DATA_W-1:0] w_ir;
    logic signed [c_pw-1:0]     w_re;
    logic signed [c_pw-1:0]     w_im;
    logic signed [c_pw-1:0]     r_re [MUL_LAT];
    logic signed [c_pw-1:0]     r_im [MUL_LAT];

    assign w_rr = a_re * b_re;
    assign w_ii = a_im * b_im;
    assign w_ri = a_re * b_im;
    assign w_ir = a_im * b_re;

    // One extra bit so the sum/difference of two products cannot overflow
    assign w_re = {w_rr[2*DATA_W-1], w_rr} - {w_ii[2*DATA_W-1], w_ii};
    assign w_im = {w_ri[2*DATA_W-1], w_ri} + {w_ir[2*DATA_W-1], w_ir};

    // Product delay line, frozen as a whole while the array is stalled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                r_re[i] <= '0;
                r_im[i] <= '0;
            end
        end else if (en) begin
            r_re[0] <= w_re;
            r_im[0] <= w_im;
            for (int i = 1; i < MUL_LAT; i++) begin
                r_re[i] <= r_re[i-1];
                r_im[i] <= r_im[i-1];
            end
        end
    end

    assign p_re = r_re[MUL_LAT-1];
    assign p_im = r_im[MUL_LAT-1];

endmodule
`default_nettype wire

// File: rtl/complex_mac_array.sv
`default_nettype none
// ============================================================================
//  Module      : complex_mac_array
//  Description : NUM_TILES image tiles multiplied element-wise by a shared
//                kernel tile, accumulated across channels, one result set
//                per channel group, valid/ready with full back-pressure.
//                Optional macro COMPLEX_MAC_SAT_EN: saturating accumulation
//                and a per-group out_sat flag (otherwise wrap, out_sat = 0).
//  Revision    : 1.0  initial parametrised release
// ============================================================================
module complex_mac_array
    import conv_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int TILE_DIM  = 4,
    parameter int NUM_TILES = 4,
    parameter int MUL_LAT   = 3,
    parameter int MAX_CH    = 256,
    parameter int ACC_W     = acc_w_f(DATA_W, MAX_CH)
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic                                          in_first,
    input  logic                                          in_last,
    input  logic [NUM_TILES*TILE_DIM*TILE_DIM*2*DATA_W-1:0] in_image,
    input  logic [TILE_DIM*TILE_DIM*2*DATA_W-1:0]           in_kernel,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [NUM_TILES*TILE_DIM*TILE_DIM*2*ACC_W-1:0]  out_acc,
    output logic                                          out_sat
);

    localparam int c_ne = NUM_TILES * TILE_DIM * TILE_DIM;
    localparam int c_ew = 2 * DATA_W;
    localparam int c_pw = 2 * DATA_W + 1;

    logic                   w_stall;
    logic                   w_en;
    logic                   w_acc_vld;
    logic                   w_pfirst;
    logic                   w_plast;
    logic                   r_vld   [MUL_LAT];
    logic                   r_first [MUL_LAT];
    logic                   r_last  [MUL_LAT];
    logic                   r_out_valid;
    logic signed [c_pw-1:0] w_prod  [2*c_ne];

    assign w_stall   = r_out_valid && !out_ready;
    assign w_en      = !w_stall;
    assign in_ready  = w_en;
    assign w_acc_vld = r_vld[MUL_LAT-1];
    assign w_pfirst  = r_first[MUL_LAT-1];
    assign w_plast   = r_last[MUL_LAT-1];
    assign out_valid = r_out_valid;

    // Beat control bits travel in lock-step with the multiplier stages
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                r_vld[i]   <= 1'b0;
                r_first[i] <= 1'b0;
                r_last[i]  <= 1'b0;
            end
        end else if (w_en) begin
            r_vld[0]   <= in_valid;
            r_first[0] <= in_first;
            r_last[0]  <= in_last;
            for (int i = 1; i < MUL_LAT; i++) begin
                r_vld[i]   <= r_vld[i-1];
                r_first[i] <= r_first[i-1];
                r_last[i]  <= r_last[i-1];
            end
        end
    end

    // Result valid: set by a last beat, dropped once taken unless refilled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
        end else if (w_en && w_acc_vld && w_plast) begin
            r_out_valid <= 1'b1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef COMPLEX_MAC_SAT_EN
    logic [2*c_ne-1:0] w_sat;
    logic              w_grp_next;
    logic              r_sat_grp;
    logic              r_out_sat;

    assign w_grp_next = (w_pfirst ? 1'b0 : r_sat_grp) | (|w_sat);
    assign out_sat    = r_out_sat;

    // Sticky per-group saturation flag, published alongside the result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sat_grp <= 1'b0;
            r_out_sat <= 1'b0;
        end else if (w_en && w_acc_vld) begin
            if (w_plast) begin
                r_out_sat <= w_grp_next;
                r_sat_grp <= 1'b0;
            end else begin
                r_sat_grp <= w_grp_next;
            end
        end
    end
`else
    assign out_sat = 1'b0;
`endif

    for (genvar t = 0; t < NUM_TILES; t++) begin : g_tile
        for (genvar r = 0; r < TILE_DIM; r++) begin : g_row
            for (genvar c = 0; c < TILE_DIM; c++) begin : g_col
                localparam int c_e    = (t * TILE_DIM + r) * TILE_DIM + c;
                localparam int c_ioff = elem_off(t, r, c, TILE_DIM, c_ew);
                localparam int c_koff = elem_off(0, r, c, TILE_DIM, c_ew);

                complex_mult_pipe #(
                    .DATA_W  (DATA_W),
                    .MUL_LAT (MUL_LAT)
                ) u_mult (
                    .clk   (clk),
                    .reset (reset),
                    .en    (w_en),
                    .a_re  (in_image[c_ioff +: DATA_W]),
                    .a_im  (in_image[c_ioff + DATA_W +: DATA_W]),
                    .b_re  (in_kernel[c_koff +: DATA_W]),
                    .b_im  (in_kernel[c_koff + DATA_W +: DATA_W]),
                    .p_re  (w_prod[2*c_e]),
                    .p_im  (w_prod[2*c_e+1])
                );

                // k = 0 real, k = 1 imag; j indexes components on out_acc
                for (genvar k = 0; k < 2; k++) begin : g_comp
                    localparam int c_j = 2 * c_e + k;

                    logic signed [ACC_W-1:0] w_pext;
                    logic signed [ACC_W-1:0] w_next;
                    logic signed [ACC_W-1:0] r_acc;
                    logic signed [ACC_W-1:0] r_oacc;

                    assign w_pext = ACC_W'(w_prod[c_j]);

`ifdef COMPLEX_MAC_SAT_EN
                    logic signed [ACC_W:0] w_wide;
                    logic                  w_hit;

                    assign w_wide = {r_acc[ACC_W-1], r_acc} + {w_pext[ACC_W-1], w_pext};

                    // Clamp to the signed range when the widened sum overflows
                    always_comb begin
                        w_next = w_wide[ACC_W-1:0];
                        w_hit  = 1'b0;
                        if (w_pfirst) begin
                            w_next = w_pext;
                        end else if (w_wide[ACC_W] != w_wide[ACC_W-1]) begin
                            w_hit  = 1'b1;
                            w_next = w_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                                   : {1'b0, {(ACC_W-1){1'b1}}};
                        end
                    end

                    assign w_sat[c_j] = w_hit & w_acc_vld;
`else
                    assign w_next = w_pfirst ? w_pext : r_acc + w_pext;
`endif

                    // Running sum; snapshot to the output and restart on last
                    always_ff @(posedge clk or negedge reset) begin
                        if (!reset) begin
                            r_acc  <= '0;
                            r_oacc <= '0;
                        end else if (w_en && w_acc_vld) begin
                            if (w_plast) begin
                                r_oacc <= w_next;
                                r_acc  <= '0;
                            end else begin
                                r_acc  <= w_next;
                            end
                        end
                    end

                    assign out_acc[c_j*ACC_W +: ACC_W] = r_oacc;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_complex_mac_array.sv
`default_nettype none
// ============================================================================
//  Module      : tb_complex_mac_array
//  Description : Randomised and directed bench for complex_mac_array with a
//                beat-level reference model (no pipeline modelling). A second
//                instance with a tiny MAX_CH exercises accumulator overflow.
//                Honours COMPLEX_MAC_SAT_EN in its expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_complex_mac_array;

    localparam int DW     = 16;
    localparam int TD     = 2;
    localparam int NT     = 2;
    localparam int ML     = 3;
    localparam int NE     = NT * TD * TD;
    localparam int KE     = TD * TD;
    localparam int ACC_W  = 2 * DW + 1 + $clog2(256);
    localparam int ACC_WS = 2 * DW + 1 + $clog2(2);
    localparam int IMG_W  = NE * 2 * DW;
    localparam int KER_W  = KE * 2 * DW;
    localparam int OUT_W  = NE * 2 * ACC_W;
    localparam int OUT_WS = NE * 2 * ACC_WS;

    typedef struct packed {
        logic [OUT_W-1:0] acc;
        logic             sat;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_first = 1'b0;
    logic              in_last = 1'b0;
    logic [IMG_W-1:0]  in_image = '0;
    logic [KER_W-1:0]  in_kernel = '0;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_acc;
    logic              out_sat;

    logic              s_in_valid = 1'b0;
    logic              s_in_ready;
    logic              s_first = 1'b0;
    logic              s_last = 1'b0;
    logic [IMG_W-1:0]  s_image = '0;
    logic [KER_W-1:0]  s_kernel = '0;
    logic              s_out_valid;
    logic [OUT_WS-1:0] s_out_acc;
    logic              s_out_sat;

    logic              dir_rdy = 1'b1;
    logic              rand_rdy = 1'b0;
    logic              rnd_rdy = 1'b1;

    int                n_tests = 0;
    int                n_fail = 0;

    exp_t              q[$];
    longint            m_acc[2*NE];
    bit                m_grp;

    assign out_ready = rand_rdy ? rnd_rdy : dir_rdy;

    always #5 clk = ~clk;

    complex_mac_array #(
        .DATA_W(DW), .TILE_DIM(TD), .NUM_TILES(NT), .MUL_LAT(ML), .MAX_CH(256)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_first(in_first), .in_last(in_last), .in_image(in_image),
        .in_kernel(in_kernel), .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .out_sat(out_sat)
    );

    complex_mac_array #(
        .DATA_W(DW), .TILE_DIM(TD), .NUM_TILES(NT), .MUL_LAT(ML), .MAX_CH(2)
    ) dut_s (
        .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_first(s_first), .in_last(s_last), .in_image(s_image),
        .in_kernel(s_kernel), .out_valid(s_out_valid), .out_ready(1'b1),
        .out_acc(s_out_acc), .out_sat(s_out_sat)
    );

    task automatic check(input string tag, input logic [1023:0] act, input logic [1023:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic longint wrapw(input longint x, input int w);
        return (x <<< (64 - w)) >>> (64 - w);
    endfunction

    // One accumulate step following the arithmetic rules of the block
    function automatic longint acc_add(input longint a, input longint p, input int w, output bit hit);
        longint s;
        s   = a + p;
        hit = 1'b0;
`ifdef COMPLEX_MAC_SAT_EN
        if (s > (longint'(1) <<< (w - 1)) - 1) begin
            s   = (longint'(1) <<< (w - 1)) - 1;
            hit = 1'b1;
        end else if (s < -(longint'(1) <<< (w - 1))) begin
            s   = -(longint'(1) <<< (w - 1));
            hit = 1'b1;
        end
        return s;
`else
        return wrapw(s, w);
`endif
    endfunction

    // Component k (0 real, 1 imag) of image element e times its kernel element
    function automatic longint prod(input logic [IMG_W-1:0] img, input logic [KER_W-1:0] ker,
                                    input int e, input int k);
        shortint ar, ai, br, bi;
        ar = img[e*2*DW +: DW];
        ai = img[e*2*DW + DW +: DW];
        br = ker[(e % KE)*2*DW +: DW];
        bi = ker[(e % KE)*2*DW + DW +: DW];
        if (k == 0) return longint'(ar) * longint'(br) - longint'(ai) * longint'(bi);
        return longint'(ar) * longint'(bi) + longint'(ai) * longint'(br);
    endfunction

    function automatic logic [IMG_W-1:0] mk_img(input shortint re, input shortint im);
        logic [IMG_W-1:0] v;
        for (int e = 0; e < NE; e++) begin
            v[e*2*DW +: DW]      = re;
            v[e*2*DW + DW +: DW] = im;
        end
        return v;
    endfunction

    function automatic logic [KER_W-1:0] mk_ker(input shortint re, input shortint im);
        logic [KER_W-1:0] v;
        for (int e = 0; e < KE; e++) begin
            v[e*2*DW +: DW]      = re;
            v[e*2*DW + DW +: DW] = im;
        end
        return v;
    endfunction

    function automatic logic [OUT_W-1:0] fill_out(input longint re, input longint im);
        logic [OUT_W-1:0] v;
        for (int e = 0; e < NE; e++) begin
            v[(2*e)*ACC_W +: ACC_W]   = re[ACC_W-1:0];
            v[(2*e+1)*ACC_W +: ACC_W] = im[ACC_W-1:0];
        end
        return v;
    endfunction

    function automatic logic [IMG_W-1:0] rnd_img();
        logic [IMG_W-1:0] v;
        for (int i = 0; i < IMG_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [KER_W-1:0] rnd_ker();
        logic [KER_W-1:0] v;
        for (int i = 0; i < KER_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference model: acts on each accepted beat, pushes one result per group
    task automatic model_beat(input logic [IMG_W-1:0] img, input logic [KER_W-1:0] ker,
                              input logic f, input logic l);
        exp_t x;
        bit   hit;
        if (f) m_grp = 1'b0;
        for (int j = 0; j < 2*NE; j++) begin
            if (f) begin
                m_acc[j] = prod(img, ker, j / 2, j % 2);
            end else begin
                m_acc[j] = acc_add(m_acc[j], prod(img, ker, j / 2, j % 2), ACC_W, hit);
                m_grp    = m_grp | hit;
            end
        end
        if (l) begin
            for (int j = 0; j < 2*NE; j++) begin
                x.acc[j*ACC_W +: ACC_W] = m_acc[j][ACC_W-1:0];
                m_acc[j] = 0;
            end
            x.sat = m_grp;
            m_grp = 1'b0;
            q.push_back(x);
        end
    endtask

    // Scoreboard: every output transfer must match the oldest expected result
    always @(negedge clk) begin
        exp_t x;
        if (!reset) begin
            q.delete();
            for (int j = 0; j < 2*NE; j++) m_acc[j] = 0;
            m_grp = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("spurious_out", 1024'(q.size()), 1024'(1));
                end else begin
                    x = q.pop_front();
                    check("out_acc", 1024'(out_acc), 1024'(x.acc));
                    check("out_sat", 1024'(out_sat), 1024'(x.sat));
                end
            end
            if (in_valid && in_ready) model_beat(in_image, in_kernel, in_first, in_last);
        end
    end

    always @(posedge clk) begin
        #1;
        rnd_rdy = ($urandom_range(0, 3) != 0);
    end

    task automatic send_beat(input logic [IMG_W-1:0] img, input logic [KER_W-1:0] ker,
                             input logic f, input logic l);
        int n;
        n         = 0;
        in_image  = img;
        in_kernel = ker;
        in_first  = f;
        in_last   = l;
        in_valid  = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) check("in_ready_timeout", 1024'(in_ready), 1024'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < budget) begin
            n++;
            @(negedge clk);
        end
        check(tag, 1024'(out_valid), 1024'(1));
    endtask

    initial begin
        logic [OUT_WS-1:0] s_exp;
        longint            s_acc;
        bit                s_any;
        bit                hit;
        int                n;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 1024'(out_valid), 1024'(0));
        check("rst_out_acc", 1024'(out_acc), 1024'(0));
        check("rst_out_sat", 1024'(out_sat), 1024'(0));
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 1024'(in_ready), 1024'(1));

        // Single first+last beat: latency and value
        send_beat(mk_img(1, 2), mk_ker(3, 4), 1'b1, 1'b1);
        for (int i = 0; i < ML; i++) begin
            @(negedge clk);
            check("t1_early", 1024'(out_valid), 1024'(0));
        end
        @(negedge clk);
        check("t1_latency", 1024'(out_valid), 1024'(1));
        check("t1_value", 1024'(out_acc), 1024'(fill_out(-5, 10)));
        check("t1_sat", 1024'(out_sat), 1024'(0));
        repeat (2) @(negedge clk);

        // Three-beat group: nothing before last, then the sum
        send_beat(mk_img(1, 2), mk_ker(3, 4), 1'b1, 1'b0);
        send_beat(mk_img(1, 2), mk_ker(3, 4), 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        check("t2_no_partial", 1024'(out_valid), 1024'(0));
        @(posedge clk);
        #1;
        send_beat(mk_img(1, 2), mk_ker(3, 4), 1'b0, 1'b1);
        wait_out("t2_timeout", 20);
        check("t2_value", 1024'(out_acc), 1024'(fill_out(-15, 30)));
        repeat (2) @(negedge clk);

        // Back-pressure: two groups held, then drained in order
        dir_rdy = 1'b0;
        send_beat(rnd_img(), rnd_ker(), 1'b1, 1'b1);
        send_beat(rnd_img(), rnd_ker(), 1'b1, 1'b1);
        repeat (8) @(negedge clk);
        check("t3_in_ready_low", 1024'(in_ready), 1024'(0));
        check("t3_held_valid", 1024'(out_valid), 1024'(1));
        @(posedge clk);
        #1;
        dir_rdy = 1'b1;
        repeat (6) @(negedge clk);
        check("t3_drained", 1024'(q.size()), 1024'(0));

        // Back-to-back last beats: out_valid high on consecutive cycles
        send_beat(rnd_img(), rnd_ker(), 1'b1, 1'b1);
        send_beat(rnd_img(), rnd_ker(), 1'b1, 1'b1);
        send_beat(rnd_img(), rnd_ker(), 1'b1, 1'b1);
        wait_out("t4_timeout", 20);
        @(negedge clk);
        check("t4_b2b_1", 1024'(out_valid), 1024'(1));
        @(negedge clk);
        check("t4_b2b_2", 1024'(out_valid), 1024'(1));
        repeat (3) @(negedge clk);

        // Reset mid-group with a held result in the output register
        dir_rdy = 1'b0;
        send_beat(rnd_img(), rnd_ker(), 1'b1, 1'b1);
        send_beat(rnd_img(), rnd_ker(), 1'b1, 1'b0);
        send_beat(rnd_img(), rnd_ker(), 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("t5_held", 1024'(out_valid), 1024'(1));
        reset = 1'b0;
        #1;
        check("t5_rst_valid", 1024'(out_valid), 1024'(0));
        check("t5_rst_acc", 1024'(out_acc), 1024'(0));
        check("t5_rst_ready", 1024'(in_ready), 1024'(1));
        @(negedge clk);
        @(posedge clk);
        #1;
        reset   = 1'b1;
        dir_rdy = 1'b1;
        send_beat(mk_img(1, 0), mk_ker(1, 0), 1'b0, 1'b1);
        wait_out("t5_timeout", 20);
        check("t5_after_rst", 1024'(out_acc), 1024'(fill_out(1, 0)));
        repeat (3) @(negedge clk);

        // Randomised groups under random back-pressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
            send_beat(rnd_img(), rnd_ker(), ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
        end
        rand_rdy = 1'b0;
        dir_rdy  = 1'b1;
        repeat (20) @(negedge clk);
        check("t6_drained", 1024'(q.size()), 1024'(0));

        // Overflow on the small-accumulator instance
        s_image  = mk_img(16'sh7FFF, 16'sh7FFF);
        s_kernel = mk_ker(16'sh7FFF, 16'sh7FFF);
        s_any    = 1'b0;
        for (int j = 0; j < 2*NE; j++) begin
            s_acc = 0;
            for (int b = 0; b < 6; b++) begin
                if (b == 0) begin
                    s_acc = prod(s_image, s_kernel, j / 2, j % 2);
                end else begin
                    s_acc = acc_add(s_acc, prod(s_image, s_kernel, j / 2, j % 2), ACC_WS, hit);
                    s_any = s_any | hit;
                end
            end
            s_exp[j*ACC_WS +: ACC_WS] = s_acc[ACC_WS-1:0];
        end
        for (int b = 0; b < 6; b++) begin
            s_in_valid = 1'b1;
            s_first    = (b == 0);
            s_last     = (b == 5);
            @(negedge clk);
            check("s_in_ready", 1024'(s_in_ready), 1024'(1));
            @(posedge clk);
            #1;
        end
        s_in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!s_out_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("sat_timeout", 1024'(s_out_valid), 1024'(1));
        check("sat_value", 1024'(s_out_acc), 1024'(s_exp));
        check("sat_flag", 1024'(s_out_sat), 1024'(s_any));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/complex_mac_array.md
Name: complex_mac_array

Overview:
- Parametrised successor to the fixed 4x4x4 complex multiplier array in the convolution engine.
- NUM_TILES parallel image tiles of TILE_DIM x TILE_DIM complex elements are multiplied element-wise against one shared kernel tile.
- Products are accumulated across input channels; one accumulated tile set is emitted per channel group.
- Sits between the FFT-domain tile buffers and the inverse-FFT stage; uses a valid/ready handshake with full back-pressure.

Parameters:
- DATA_W, 16, signed fixed-point width of each real/imag input component.
- TILE_DIM, 4, tile edge; the tile holds TILE_DIM*TILE_DIM complex elements.
- NUM_TILES, 4, image tiles processed in parallel against the same kernel.
- MUL_LAT, 3, pipeline depth of complex multiplier, >=1.
- MAX_CH, 256, maximum channels per accumulation group.
- ACC_W, 2*DATA_W+1+$clog2(MAX_CH), accumulator width per component (derived; do not override).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept beat
- in_first  in  1  beat is first channel of group; accumulator reloads
- in_last  in  1  beat is last channel of group; result emitted
- in_image  in  NUM_TILES*TILE_DIM*TILE_DIM*2*DATA_W  packed image tiles {imag,real} per element, tile-major, row-major
- in_kernel  in  TILE_DIM*TILE_DIM*2*DATA_W  packed kernel tile, same ordering
- out_valid  out  1  accumulated result valid
- out_ready  in  1  downstream accepts result
- out_acc  out  NUM_TILES*TILE_DIM*TILE_DIM*2*ACC_W  accumulated tiles, same ordering
- out_sat  out  1  any component saturated in this group (0 when feature compiled out)

Behaviour:
- Reset (reset low, asynchronous): out_valid=0, out_acc=0, out_sat=0, all pipeline valid bits=0, accumulators=0. in_ready=1 after release.
- Transfer occurs when in_valid&&in_ready. Output transfer occurs when out_valid&&out_ready.
- stall = out_valid && !out_ready. in_ready = !stall (combinational). While stalled, the whole pipeline, including multipliers and accumulators, holds.
- Multiply: re = ar*br - ai*bi, im = ar*bi + ai*br, full precision 2*DATA_W+1 bits, sign-extended to ACC_W. Latency MUL_LAT. first/last/valid travel alongside.
- Accumulate stage, one cycle, on a valid product: acc = first ? prod : acc + prod. If last, out_acc is loaded with the new acc value and out_valid is set. Accumulator is then cleared to 0.
- Latency: an accepted beat with in_last at cycle t gives out_valid high at t+MUL_LAT+1, absent stalls.
- out_valid clears on output transfer unless a new last result loads in the same cycle; then it stays 1 with new data.
- first and last on the same beat: result equals that beat's product alone.
- last with no preceding first: accumulates onto current accumulator (0 after reset or after previous emit).
- Two consecutive firsts without last: second discards the first partial sum. Not an error.
- Overflow without the feature: two's-complement wrap at ACC_W.
- Reset mid-group: partial sums and in-flight beats are discarded; no output is produced.

Optional Feature:
- COMPLEX_MAC_SAT_EN defined: each accumulate addition saturates per component to ±(2^(ACC_W-1)-1 / -2^(ACC_W-1)). out_sat latches 1 if any component saturated during the group; it is presented with out_acc and cleared at the next first.
- Undefined: additions wrap; out_sat is tied to 0.

Decomposition:
- Shared package conv_pkg: element-index helper function (tile, row, col → bit offset), ACC_W derivation function, and a cplx_fixed struct typedef parametrised by localparam widths.
- Natural sub-module: complex_mult_pipe. It implements one complex multiply with MUL_LAT registered stages and an enable (!stall) input. It is instantiated NUM_TILES*TILE_DIM*TILE_DIM times.
- Accumulate, handshake, and saturation logic live in the top.

Test Plan (DATA_W=16, TILE_DIM=2, NUM_TILES=2, MUL_LAT=3):
- Single beat, first=last=1, all image 1+2j, kernel 3+4j → out_valid at cycle t+4; every element -5+10j; out_sat=0.
- Three beats (first, mid, last) with the same data → single output; every element -15+30j; no output after first/mid beats.
- Hold out_ready=0 while two groups are sent → in_ready drops when first result is held; second result is not lost; both groups appear in order after out_ready=1.
- Back-to-back last beats with out_ready=1 → out_valid stays high across consecutive cycles with distinct data.
- Assert reset low mid-group (after 2 of 3 beats) → outputs zero immediately; after release, one-beat group 1+0j*1+0j gives 1+0j.
- With COMPLEX_MAC_SAT_EN: MAX_CH forced small, 0x7FFF+0x7FFFj squared repeatedly past ACC_W → imag component pinned at max positive; out_sat=1. Without the macro: wrapped value and out_sat=0.
